display_scan_controller: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-cathode 7-segment display.
- Shares one BCD-to-7-segment decoder across all digits: it sequences the digit enables, inserts anti-ghosting blank intervals and handles leading-zero blanking.
- Latches new display data only at frame boundaries, using a load handshake, so the display never shows a torn value.
- Sits between the application counter/data logic and the board display pins; replaces the single-digit direct drive.

---
 rtl/display_scan_controller_pkg.sv | 21 ++
 rtl/display_scan_controller_if.sv | 12 +
 rtl/display_scan_controller_seg7_hex_decoder.sv | 15 +
 rtl/display_scan_controller.sv | 153 +++++++++++++++
 tb/tb_display_scan_controller.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Glyphs are active-high with segment a on bit 0 through segment g on bit 6.
package display_scan_controller_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Hex glyph table: 0-9, then A b C d E F
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/display_scan_controller_if.sv
// Load handshake between the data source and the scan controller's shadow registers.
interface display_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load_req;
  logic                    load_ack;

  modport master (output bcd_in, output dp_in, output load_req, input load_ack);
  modport slave  (input bcd_in, input dp_in, input load_req, output load_ack);
endinterface

// File: rtl/display_scan_controller_seg7_hex_decoder.sv
// Combinational hex digit to 7-segment glyph decoder with a blanking override.
module seg7_hex_decoder
  import display_scan_controller_pkg::*;
(
  input  logic [DIG_W-1:0] value,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    if (!blank) seg_c = GLYPH[value];
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed N-digit 7-segment scan controller with blank gaps,
// leading-zero blanking and frame-aligned shadow loading.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL_CYC  = 50000,
  parameter int unsigned BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_blank,
  display_scan_controller_if.slave load_if,
  output logic                    frame_done,
  output logic [SEG_W-1:0]        Segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en_n
);

  localparam int unsigned DATA_W  = DIG_W * NUM_DIGITS;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_done_q, frame_done_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_n_q, en_n_d;

  logic                    accept;
  logic                    last_idx;
  logic [DIG_W-1:0]        dig_val;
  logic                    upper_zero;
  logic                    lz_hit;
  logic [SEG_W-1:0]        dec_seg_c;

  assign last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Next-state: scan sequencing and load acceptance
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    dp_sh_d      = dp_sh_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    accept       = 1'b0;

    if (!enable) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
      accept  = load_if.load_req && !load_ack_q;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CNT_W'(DWELL_CYC - 1)) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = last_idx ? '0 : idx_q + IDX_W'(1);
            if (last_idx) begin
              frame_done_d = 1'b1;
              accept       = load_if.load_req && !load_ack_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    if (accept) begin
      shadow_d   = load_if.bcd_in;
      dp_sh_d    = load_if.dp_in;
      load_ack_d = 1'b1;
    end
  end

  // Digit i is blanked when it and every more-significant digit are zero
  always_comb begin
    dig_val    = DIG_W'(shadow_d >> {idx_d, 2'b00});
    upper_zero = ((shadow_d >> {idx_d, 2'b00}) == '0);
    lz_hit     = lz_blank && (idx_d != '0) && upper_zero;
  end

  seg7_hex_decoder u_dec (
    .value (dig_val),
    .blank (lz_hit),
    .seg_c (dec_seg_c)
  );

  // Output decode from the upcoming state so pins track the state register
  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = 1'b0;
    en_n_d = '1;
    if (state_d == ST_DRIVE) begin
      seg_d  = dec_seg_c;
      dp_d   = dp_sh_d[idx_d];
      en_n_d = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      dp_sh_q      <= '0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      en_n_q       <= '1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      en_n_q       <= en_n_d;
    end
  end

  assign load_if.load_ack = load_ack_q;
  assign frame_done       = frame_done_q;
  assign Segments         = seg_q;
  assign dp               = dp_q;
  assign digit_en_n       = en_n_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a frame-position model
// (NUM_DIGITS=4, DWELL_CYC=4, BLANK_CYC=2).
module tb_display_scan_controller;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          lz_blank;
  logic          frame_done;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] den;

  display_scan_controller_if #(.NUM_DIGITS(ND)) lb ();

  display_scan_controller #(
    .NUM_DIGITS (ND),
    .DWELL_CYC  (DW),
    .BLANK_CYC  (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_if    (lb),
    .frame_done (frame_done),
    .Segments   (seg),
    .dp         (dp),
    .digit_en_n (den)
  );

  always #5 clk = ~clk;

  a_one_digit: assert property (@(negedge clk) $onehot0(~den))
    else $error("FAIL onehot digit_en_n=%b", den);

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Model: enabled-edge count since restart, shadow contents, last sampled lz, ack
  int            m_s    = 0;
  logic [15:0]   m_sh   = '0;
  logic [ND-1:0] m_dpsh = '0;
  logic          m_lz   = 1'b0;
  logic          m_ack  = 1'b0;

  string glyph_txt [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g = '0;
    string t = glyph_txt[v];
    int k;
    for (int i = 0; i < t.len(); i++) begin
      k = int'(t.getc(i)) - 97;
      g[k] = 1'b1;
    end
    return g;
  endfunction

  function automatic bit driving();
    return ((m_s % FRAME) % SLOT) >= BL;
  endfunction

  function automatic int digit();
    return (m_s % FRAME) / SLOT;
  endfunction

  function automatic logic [ND-1:0] exp_en();
    if (!driving()) return '1;
    return ~(ND'(1) << digit());
  endfunction

  function automatic logic [6:0] exp_seg();
    int d = digit();
    if (!driving()) return 7'h00;
    if (d > 0 && m_lz && (m_sh >> (4 * d)) == 16'h0) return 7'h00;
    return glyph(4'(m_sh >> (4 * d)));
  endfunction

  function automatic logic exp_dp();
    return driving() && m_dpsh[digit()];
  endfunction

  function automatic logic exp_fd();
    return (m_s > 0) && (m_s % FRAME == 0);
  endfunction

  // One clock: capture inputs seen by the edge, advance model, requester drops req on ack
  task automatic tick();
    logic          r = rst;
    logic          e = enable;
    logic          q = lb.load_req;
    logic          l = lz_blank;
    logic [15:0]   b = lb.bcd_in;
    logic [ND-1:0] d = lb.dp_in;
    @(posedge clk);
    #1;
    cyc++;
    m_ack = 1'b0;
    if (r) begin
      m_s = 0; m_sh = '0; m_dpsh = '0;
    end else if (!e) begin
      m_s = 0;
      if (q) begin m_sh = b; m_dpsh = d; m_ack = 1'b1; end
    end else begin
      m_s++;
      if (q && exp_fd()) begin m_sh = b; m_dpsh = d; m_ack = 1'b1; end
    end
    m_lz = l;
    if (lb.load_ack) lb.load_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; lz_blank = 1'b0;
    lb.load_req = 1'b0; lb.bcd_in = 16'hFFFF; lb.dp_in = '1;
    tick(); tick();
    checks++;
    if ({den, seg, dp, frame_done, lb.load_ack} !== {4'b1111, 7'h00, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset en/seg/dp/fd/ack got %b/%h/%b/%b/%b want 1111/00/0/0/0",
               den, seg, dp, frame_done, lb.load_ack);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_scan();
    enable = 1'b1;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      tick();
      checks++;
      if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
        $display("FAIL scan cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b", cyc,
                 den, seg, dp, frame_done, lb.load_ack, exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
      else passed++;
    end
  endtask

  task automatic test_load_frame();
    int k = $urandom_range(3, 18);
    for (int c = 0; c < k + 2 * FRAME; c++) begin
      if (c == k) begin
        lb.bcd_in = 16'h1234; lb.dp_in = 4'b0100; lb.load_req = 1'b1;
      end
      tick();
      checks++;
      if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
        $display("FAIL load1234 cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b", cyc,
                 den, seg, dp, frame_done, lb.load_ack, exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
      else passed++;
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [4] = '{16'h0007, 16'h0000, 16'h00AF, 16'h00AF};
    logic        lzs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      lz_blank = lzs[t];
      lb.bcd_in = vals[t]; lb.dp_in = 4'($urandom); lb.load_req = 1'b1;
      for (int c = 0; c < 2 * FRAME; c++) begin
        tick();
        checks++;
        if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
          $display("FAIL lzblank val=%h cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b",
                   vals[t], cyc, den, seg, dp, frame_done, lb.load_ack,
                   exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
        else passed++;
      end
    end
  endtask

  task automatic test_enable_toggle();
    bit hit = 1'b0;
    enable = 1'b1; lz_blank = 1'b0;
    for (int c = 0; c < 2 * FRAME && !hit; c++) begin
      tick();
      hit = driving() && (digit() == 2);
    end
    checks++;
    if (!hit) $display("FAIL en_wait digit2 dwell got none want within %0d cycles", 2 * FRAME);
    else passed++;
    enable = 1'b0;
    for (int c = 0; c < 4 + FRAME; c++) begin
      if (c == 1) begin
        lb.bcd_in = 16'($urandom); lb.dp_in = 4'($urandom); lb.load_req = 1'b1;
      end
      if (c == 3) enable = 1'b1;
      tick();
      checks++;
      if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
        $display("FAIL entoggle cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b", cyc,
                 den, seg, dp, frame_done, lb.load_ack, exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
      else passed++;
    end
  endtask

  task automatic test_rst_pending();
    bit hit = 1'b0;
    for (int c = 0; c < FRAME && !hit; c++) begin
      tick();
      hit = driving();
    end
    lb.bcd_in = 16'h9876; lb.dp_in = 4'b1111; lb.load_req = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; lb.load_req = 1'b0; lz_blank = 1'b0;
    for (int c = 0; c < FRAME + 2; c++) begin
      checks++;
      if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
        $display("FAIL rstpend cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b", cyc,
                 den, seg, dp, frame_done, lb.load_ack, exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
      else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      lb.bcd_in = 16'($urandom); lb.dp_in = 4'($urandom); lb.load_req = 1'b1;
      for (int c = 0; c < 2 * FRAME; c++) begin
        lz_blank = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if ({den, seg, dp, frame_done, lb.load_ack} !== {exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack})
          $display("FAIL random cyc=%0d en/seg/dp/fd/ack got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b", cyc,
                   den, seg, dp, frame_done, lb.load_ack, exp_en(), exp_seg(), exp_dp(), exp_fd(), m_ack);
        else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_load_frame();
    test_lz_blank();
    test_enable_toggle();
    test_rst_pending();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
